// File: rtl/game_state_gen.sv
// Game-mode controller: synchronises/debounces btnR, btnL and pauseSwitch and runs the
// START/GAME/PAUSE/COMBO/OVER machine. Define BTN_DEBOUNCE_EN to include the debouncers.
module game_state_gen #(
    parameter int         STATE_BITS   = 2,
    parameter logic [2:0] ST_START     = 3'd0,
    parameter logic [2:0] ST_GAME      = 3'd1,
    parameter logic [2:0] ST_PAUSE     = 3'd2,
    parameter logic [2:0] ST_COMBO     = 3'd3,
    parameter logic [2:0] ST_OVER      = 3'd4,
    parameter int         DEB_CYCLES   = 500000,
    parameter int         COMBO_CYCLES = 25000000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  btnR,
    input  logic                  btnL,
    input  logic                  pauseSwitch,
    input  logic                  game_over,
    output logic [STATE_BITS:0]   output_state,
    output logic                  display_combo_en
);

    localparam int SW = STATE_BITS + 1;
    localparam int CW = (COMBO_CYCLES > 1) ? $clog2(COMBO_CYCLES) : 1;
    localparam logic [CW-1:0] COMBO_LAST = CW'(COMBO_CYCLES - 1);

    typedef enum logic [2:0] {
        S_START = ST_START,
        S_GAME  = ST_GAME,
        S_PAUSE = ST_PAUSE,
        S_COMBO = ST_COMBO,
        S_OVER  = ST_OVER
    } state_t;

    // Bit 0 = btnR, bit 1 = btnL, bit 2 = pause switch
    logic [2:0] raw_in;
    logic [2:0] stable_lvl;
    logic [2:0] press;

    assign raw_in = {pauseSwitch, btnL, btnR};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_in
            logic sync1_reg;
            logic sync2_reg;
            logic stable_prev_reg;
            logic stable_w;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    sync1_reg       <= 1'b0;
                    sync2_reg       <= 1'b0;
                    stable_prev_reg <= 1'b0;
                end else begin
                    sync1_reg       <= raw_in[gi];
                    sync2_reg       <= sync1_reg;
                    stable_prev_reg <= stable_w;
                end
            end

`ifdef BTN_DEBOUNCE_EN
            localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
            localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

            logic [DW-1:0] deb_cnt_reg;
            logic          stable_reg;

            // Accept the new level only after an unbroken run of mismatching samples
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    deb_cnt_reg <= '0;
                    stable_reg  <= 1'b0;
                end else if (sync2_reg != stable_reg) begin
                    if (deb_cnt_reg == DEB_LAST) begin
                        stable_reg  <= sync2_reg;
                        deb_cnt_reg <= '0;
                    end else begin
                        deb_cnt_reg <= deb_cnt_reg + 1'b1;
                    end
                end else begin
                    deb_cnt_reg <= '0;
                end
            end

            assign stable_w = stable_reg;
`else
            assign stable_w = sync2_reg;
`endif

            assign stable_lvl[gi] = stable_w;
            assign press[gi]      = stable_w & ~stable_prev_reg;
        end
    endgenerate

    logic press_r;
    logic press_l;
    logic pause_lvl;

    assign press_r   = press[0];
    assign press_l   = press[1];
    assign pause_lvl = stable_lvl[2];

    state_t        state_reg, state_next;
    logic [CW-1:0] combo_cnt_reg, combo_cnt_next;
    logic          combo_en_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= S_START;
            combo_cnt_reg <= '0;
            combo_en_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            combo_cnt_reg <= combo_cnt_next;
            combo_en_reg  <= (state_next == S_COMBO);
        end
    end

    always_comb begin
        state_next     = state_reg;
        combo_cnt_next = combo_cnt_reg;
        case (state_reg)
            S_START: begin
                if (press_r) state_next = S_GAME;
            end
            S_GAME: begin
                if (game_over) begin
                    state_next = S_OVER;
                end else if (pause_lvl) begin
                    state_next = S_PAUSE;
                end else if (press_l) begin
                    state_next     = S_COMBO;
                    combo_cnt_next = '0;
                end
            end
            S_COMBO: begin
                if (game_over) begin
                    state_next     = S_OVER;
                    combo_cnt_next = '0;
                end else if (pause_lvl) begin
                    state_next     = S_PAUSE;
                    combo_cnt_next = '0;
                end else if (press_l) begin
                    combo_cnt_next = '0;
                end else if (combo_cnt_reg == COMBO_LAST) begin
                    state_next     = S_GAME;
                    combo_cnt_next = '0;
                end else begin
                    combo_cnt_next = combo_cnt_reg + 1'b1;
                end
            end
            S_PAUSE: begin
                if (!pause_lvl) state_next = S_GAME;
            end
            S_OVER: begin
                if (press_r) state_next = S_START;
            end
            default: begin
                state_next     = S_START;
                combo_cnt_next = '0;
            end
        endcase
    end

    assign output_state     = SW'(state_reg);
    assign display_combo_en = combo_en_reg;

endmodule

// File: tb/tb_game_state_gen.sv
// Scoreboard bench for game_state_gen (DEB_CYCLES=4, COMBO_CYCLES=10); adapts to BTN_DEBOUNCE_EN.
module tb_game_state_gen;

`ifdef BTN_DEBOUNCE_EN
    localparam int LAT = 7;
`else
    localparam int LAT = 3;
`endif

    logic       clk;
    logic       reset;
    logic       btnR;
    logic       btnL;
    logic       pauseSwitch;
    logic       game_over;
    logic [2:0] output_state;
    logic       display_combo_en;

    game_state_gen #(
        .DEB_CYCLES   (4),
        .COMBO_CYCLES (10)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .btnR             (btnR),
        .btnL             (btnL),
        .pauseSwitch      (pauseSwitch),
        .game_over        (game_over),
        .output_state     (output_state),
        .display_combo_en (display_combo_en)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int         checks   = 0;
    int         failures = 0;
    logic [3:0] exp_q[$];
    string      name_q[$];
    event       chk_ev;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Push the expected {state, combo_en} and signal the monitor to sample
    task automatic chk(input string nm, input logic [2:0] st, input logic ce);
        name_q.push_back(nm);
        exp_q.push_back({st, ce});
        ->chk_ev;
        #2;
    endtask

    initial begin
        logic [3:0] e;
        string      nm;
        forever begin
            @(chk_ev);
            #1;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL scoreboard_empty: no expected entry queued");
            end else begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                if (output_state !== e[3:1] || display_combo_en !== e[0]) begin
                    failures++;
                    $display("FAIL %s: state=%0d combo_en=%0b required state=%0d combo_en=%0b",
                             nm, output_state, display_combo_en, e[3:1], e[0]);
                end else begin
                    $display("check %s: state=%0d combo_en=%0b", nm, output_state, display_combo_en);
                end
            end
        end
    end

    initial begin
        reset = 1'b0; btnR = 1'b0; btnL = 1'b0; pauseSwitch = 1'b0; game_over = 1'b0;
        cyc(3);
        chk("reset_state", 3'd0, 1'b0);
        reset = 1'b1;
        cyc(2);

`ifdef BTN_DEBOUNCE_EN
        for (int i = 0; i < 10; i++) begin
            btnR = ~btnR;
            cyc(2);
        end
        btnR = 1'b0;
        cyc(LAT + 4);
        chk("bounce_no_press", 3'd0, 1'b0);
`else
        btnR = 1'b1;
        cyc(1);
        btnR = 1'b0;
        cyc(1);
        chk("pulse_lat2", 3'd0, 1'b0);
        cyc(1);
        chk("pulse_lat3", 3'd1, 1'b0);
        reset = 1'b0;
        cyc(1);
        reset = 1'b1;
        cyc(2);
`endif

        // Start press latency and hold
        btnR = 1'b1;
        cyc(LAT - 1);
        chk("start_before", 3'd0, 1'b0);
        cyc(1);
        chk("start_to_game", 3'd1, 1'b0);
        cyc(100 - LAT);
        chk("held_no_repress", 3'd1, 1'b0);
        btnR = 1'b0;
        cyc(LAT + 2);

        // Combo banner duration
        btnL = 1'b1;
        cyc(LAT - 1);
        chk("combo_before", 3'd1, 1'b0);
        cyc(1);
        chk("combo_enter", 3'd3, 1'b1);
        btnL = 1'b0;
        cyc(9);
        chk("combo_last", 3'd3, 1'b1);
        cyc(1);
        chk("combo_exit", 3'd1, 1'b0);
        cyc(LAT + 2);
        chk("combo_no_reenter", 3'd1, 1'b0);

        // game_over and pause in the same cycle during combo
        btnL = 1'b1;
        cyc(LAT);
        chk("combo2_enter", 3'd3, 1'b1);
        btnL = 1'b0;
        pauseSwitch = 1'b1;
        cyc(LAT - 1);
        game_over = 1'b1;
        cyc(1);
        game_over = 1'b0;
        chk("go_beats_pause", 3'd4, 1'b0);
        btnL = 1'b1;
        cyc(LAT + 1);
        chk("over_ignores_l", 3'd4, 1'b0);
        btnL = 1'b0;
        pauseSwitch = 1'b0;
        cyc(LAT + 2);
        btnR = 1'b1;
        cyc(LAT);
        chk("over_to_start", 3'd0, 1'b0);
        btnR = 1'b0;
        cyc(LAT + 2);

        // Pause during combo, resume into game
        btnR = 1'b1;
        cyc(LAT);
        chk("restart_game", 3'd1, 1'b0);
        btnR = 1'b0;
        cyc(LAT + 2);
        btnL = 1'b1;
        cyc(LAT);
        chk("combo3_enter", 3'd3, 1'b1);
        btnL = 1'b0;
        pauseSwitch = 1'b1;
        cyc(LAT - 1);
        chk("pause_before", 3'd3, 1'b1);
        cyc(1);
        chk("combo_to_pause", 3'd2, 1'b0);
        pauseSwitch = 1'b0;
        cyc(LAT - 1);
        chk("pause_hold", 3'd2, 1'b0);
        cyc(1);
        chk("pause_to_game", 3'd1, 1'b0);
        cyc(12);
        chk("no_combo_resume", 3'd1, 1'b0);

        // Asynchronous reset in the middle of a combo
        btnL = 1'b1;
        cyc(LAT);
        chk("combo4_enter", 3'd3, 1'b1);
        btnL = 1'b0;
        cyc(3);
        reset = 1'b0;
        chk("async_reset", 3'd0, 1'b0);
        cyc(2);
        reset = 1'b1;
        cyc(2);

        // Switch already on when the game starts
        pauseSwitch = 1'b1;
        cyc(LAT + 2);
        chk("start_ignores_pause", 3'd0, 1'b0);
        btnR = 1'b1;
        cyc(LAT);
        chk("game_entered", 3'd1, 1'b0);
        cyc(1);
        chk("auto_pause", 3'd2, 1'b0);
        btnR = 1'b0;

        cyc(2);
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
